aes_key_schedule_ctrl: RTL and testbench

//   Iterative AES-128 key-schedule sequencer. Accepts a cipher key over valid/ready.

---
 rtl/aes_pkg.sv | 66 ++++++
 rtl/key_expansion_stage.sv | 61 ++++++
 rtl/aes_key_schedule_ctrl.sv | 177 +++++++++++++++++
 tb/tb_aes_key_schedule_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions.
//   AES_KEY_W / AES_NUM_ROUNDS : AES-128 key width and expansion round count
//   aes_key_t / aes_round_t    : round-key word and round-index types
//   aes_state_t                : key-schedule sequencer states
//   aes_sbox / aes_sub_word / aes_rcon : byte substitution and round constants
package aes_pkg;

    localparam int AES_KEY_W      = 128;
    localparam int AES_NUM_ROUNDS = 10;

    typedef logic [127:0] aes_key_t;
    typedef logic [3:0]   aes_round_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } aes_state_t;

    // Forward S-box, byte 0 in the leftmost position.
    localparam logic [0:2047] AES_SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] aes_sbox(input logic [7:0] b);
        return AES_SBOX[int'(b) * 8 +: 8];
    endfunction

    function automatic logic [31:0] aes_sub_word(input logic [31:0] w);
        return {aes_sbox(w[31:24]), aes_sbox(w[23:16]),
                aes_sbox(w[15:8]),  aes_sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] aes_rcon(input aes_round_t r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/key_expansion_stage.sv
// One AES-128 key-expansion round with a fixed output latency.
//   clk, rstn  : clock, synchronous active-low reset (valid pipeline only)
//   in_valid   : in_key / round_idx presented this cycle
//   in_key     : previous round key
//   round_idx  : round being generated (1..10), selects Rcon
//   out_valid  : out_key valid, STAGE_LAT cycles after in_valid
//   out_key    : next round key
module key_expansion_stage
    import aes_pkg::*;
#(
    parameter int STAGE_LAT = 1
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       in_valid,
    input  aes_key_t   in_key,
    input  aes_round_t round_idx,
    output logic       out_valid,
    output aes_key_t   out_key
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] temp;
    logic [31:0] n0, n1, n2, n3;
    aes_key_t    nxt_key;

    assign {w0, w1, w2, w3} = in_key;
    // RotWord then SubWord on the last word, folded with the round constant.
    assign temp = aes_sub_word({w3[23:0], w3[31:24]}) ^ {aes_rcon(round_idx), 24'h0};
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign nxt_key = {n0, n1, n2, n3};

    aes_key_t             key_p [STAGE_LAT];
    logic [STAGE_LAT-1:0] vld_p;

    // ---- stage boundary: combinational round -> latency pipeline ----
    always_ff @(posedge clk) begin
        key_p[0] <= nxt_key;
        for (int i = 1; i < STAGE_LAT; i++) begin
            key_p[i] <= key_p[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= in_valid;
            for (int i = 1; i < STAGE_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
        end
    end

    assign out_key   = key_p[STAGE_LAT-1];
    assign out_valid = vld_p[STAGE_LAT-1];

endmodule

// File: rtl/aes_key_schedule_ctrl.sv
// Iterative AES-128 key-schedule sequencer with a flop-based round-key buffer.
//   clk, rst     : clock, synchronous active-high reset
//   key_valid/key_ready/key_in : cipher-key load handshake
//   busy         : expansion in progress
//   keys_ready   : all NUM_ROUNDS+1 round keys valid
//   rk_rd_en/rk_rd_idx : round-key read request
//   rk_rd_valid/rk_rd_err/rk_rd_data : registered read response, 1 cycle later
//   zeroize      : (AES_KS_ZEROIZE_EN only) wipe buffer and abort expansion
// Optional feature macro: AES_KS_ZEROIZE_EN.
module aes_key_schedule_ctrl
    import aes_pkg::*;
#(
    parameter int KEY_W      = AES_KEY_W,
    parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int STAGE_LAT  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    output logic             key_ready,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             keys_ready,
    input  logic             rk_rd_en,
    input  logic [3:0]       rk_rd_idx,
    output logic             rk_rd_valid,
    output logic             rk_rd_err,
    output logic [KEY_W-1:0] rk_rd_data
`ifdef AES_KS_ZEROIZE_EN
    ,
    input  logic             zeroize
`endif
);

    localparam aes_round_t LAST_ROUND = aes_round_t'(NUM_ROUNDS);
    localparam int         WAIT_W     = (STAGE_LAT > 1) ? $clog2(STAGE_LAT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(STAGE_LAT - 1);

    aes_state_t        state;
    aes_round_t        round;
    aes_round_t        done_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    aes_key_t          rk [NUM_ROUNDS+1];

    logic     zero_req;
    logic     clear_on_load;
    logic     accept;
    logic     capture;
    aes_key_t stg_in_key;
    aes_key_t stg_out_key;
    logic     stg_out_valid;
    aes_key_t rd_word;
    logic     rd_err;

`ifdef AES_KS_ZEROIZE_EN
    assign zero_req      = zeroize;
    assign clear_on_load = 1'b1;
`else
    assign zero_req      = 1'b0;
    assign clear_on_load = 1'b0;
`endif

    // Zeroize wins over a simultaneous key handshake.
    assign accept  = key_valid && key_ready && !zero_req;
    assign capture = (state == WAIT) && stg_out_valid && (wait_cnt == WAIT_LAST);

    // Previous round key feeds the stage; round and rk only move on capture,
    // so the stage inputs stay stable for the whole WAIT period.
    always_comb begin
        stg_in_key = '0;
        for (int i = 0; i < NUM_ROUNDS; i++) begin
            if (aes_round_t'(i + 1) == round) stg_in_key = rk[i];
        end
    end

    key_expansion_stage #(
        .STAGE_LAT (STAGE_LAT)
    ) u_stage (
        .clk       (clk),
        .rstn      (~rst),
        .in_valid  (state == ISSUE),
        .in_key    (stg_in_key),
        .round_idx (round),
        .out_valid (stg_out_valid),
        .out_key   (stg_out_key)
    );

    // ---- stage boundary: sequencer control ----
    // DONE spends one cycle before raising keys_ready/key_ready so the final
    // round key has been in the buffer for a full cycle when announced.
    always_ff @(posedge clk) begin
        if (rst || zero_req) begin
            state      <= IDLE;
            key_ready  <= 1'b1;
            busy       <= 1'b0;
            keys_ready <= 1'b0;
            done_cnt   <= '0;
            round      <= '0;
            wait_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= ISSUE;
                        key_ready  <= 1'b0;
                        busy       <= 1'b1;
                        keys_ready <= 1'b0;
                        done_cnt   <= 4'd1;
                        round      <= 4'd1;
                    end else if (state == DONE) begin
                        key_ready  <= 1'b1;
                        keys_ready <= 1'b1;
                    end
                end
                ISSUE: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (capture) begin
                        done_cnt <= round + 4'd1;
                        if (round == LAST_ROUND) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            round <= round + 4'd1;
                            state <= ISSUE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- stage boundary: round-key buffer ----
    always_ff @(posedge clk) begin
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (zero_req) begin
                rk[i] <= '0;
            end else if (accept) begin
                if (i == 0)             rk[i] <= aes_key_t'(key_in);
                else if (clear_on_load) rk[i] <= '0;
            end else if (capture && (aes_round_t'(i) == round)) begin
                rk[i] <= stg_out_key;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        for (int i = 0; i <= NUM_ROUNDS; i++) begin
            if (aes_round_t'(i) == rk_rd_idx) rd_word = rk[i];
        end
    end

    // A read coinciding with a reload or wipe must never expose the old key,
    // and an entry being captured this cycle is not yet readable.
    assign rd_err = (rk_rd_idx > LAST_ROUND) || (rk_rd_idx >= done_cnt) ||
                    accept || zero_req;

    // ---- stage boundary: registered read response ----
    always_ff @(posedge clk) begin
        if (rst) begin
            rk_rd_valid <= 1'b0;
            rk_rd_err   <= 1'b0;
            rk_rd_data  <= '0;
        end else begin
            rk_rd_valid <= rk_rd_en;
            rk_rd_err   <= rk_rd_en && rd_err;
            rk_rd_data  <= (rk_rd_en && !rd_err) ? rd_word : '0;
        end
    end

endmodule

// File: tb/tb_aes_key_schedule_ctrl.sv
// Scoreboard bench for aes_key_schedule_ctrl. A FIPS-197 style key expansion
// (S-box derived from GF(2^8) inversion) and a cycle-level timing model predict
// status outputs and read responses; a monitor pops expected read responses.
module tb_aes_key_schedule_ctrl;

    logic         clk;
    logic         rst;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         busy;
    logic         keys_ready;
    logic         rk_rd_en;
    logic [3:0]   rk_rd_idx;
    logic         rk_rd_valid;
    logic         rk_rd_err;
    logic [127:0] rk_rd_data;
`ifdef AES_KS_ZEROIZE_EN
    logic         zeroize;
`endif

    aes_key_schedule_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .key_ready   (key_ready),
        .key_in      (key_in),
        .busy        (busy),
        .keys_ready  (keys_ready),
        .rk_rd_en    (rk_rd_en),
        .rk_rd_idx   (rk_rd_idx),
        .rk_rd_valid (rk_rd_valid),
        .rk_rd_err   (rk_rd_err),
        .rk_rd_data  (rk_rd_data)
`ifdef AES_KS_ZEROIZE_EN
        ,
        .zeroize     (zeroize)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           ed;
        bit           err;
        logic [127:0] data;
    } exp_t;

    exp_t         sb[$];
    int           total = 0;
    int           bad = 0;
    int           pe = 0;
    bit           have_key = 0;
    int           ea = 0;
    logic [127:0] exp_rk [0:10];
    logic [7:0]   sbox_tab [0:255];

    always @(posedge clk) pe <= pe + 1;

    // ---------------- reference model ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = xt(x);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, b;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int x = 1; x < 256; x++) begin
                if (a != 0 && gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            end
            b = inv;
            sbox_tab[a] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^
                          {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
    endfunction

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int j = 0; j < 11; j++) exp_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    // ---------------- checking ----------------
    task automatic cmp1(input string nm, input int ed, input logic act, input bit want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s after edge %0d: got %b want %b", nm, ed, act, want);
        end
    endtask

    // Status outputs after edge L: expansion spans edges ea..ea+20, keys_ready
    // and key_ready rise 21 edges after the accepting edge.
    task automatic check_status(input int L);
        cmp1("key_ready",  L, key_ready,  !have_key || (L >= ea + 21));
        cmp1("busy",       L, busy,       have_key && (L < ea + 20));
        cmp1("keys_ready", L, keys_ready, have_key && (L >= ea + 21));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].ed == pe - 1) begin
            e = sb.pop_front();
            total++;
            if (rk_rd_valid !== 1'b1 || rk_rd_err !== e.err || rk_rd_data !== e.data) begin
                bad++;
                $display("FAIL rd_resp edge %0d: got v=%b err=%b data=%h want v=1 err=%b data=%h",
                         e.ed, rk_rd_valid, rk_rd_err, rk_rd_data, e.err, e.data);
            end
        end else begin
            total++;
            if (rk_rd_valid !== 1'b0) begin
                bad++;
                $display("FAIL rd_valid_idle after edge %0d: got %b want 0", pe - 1, rk_rd_valid);
            end
        end
    end

    // ---------------- stimulus ----------------
    // One cycle: check status of the previous edge, drive inputs for the next
    // edge, predict its effect and queue the expected read response.
    task automatic tick(input bit v, input logic [127:0] k, input bit en, input logic [3:0] idx,
                        input bit r, input bit z, input bit pin, input logic [127:0] pin_val);
        int   ec;
        bit   acc, ok;
        exp_t e;
        @(negedge clk);
        ec = pe;
        check_status(pe - 1);
        key_valid = v;
        key_in    = k;
        rk_rd_en  = en && !r;
        rk_rd_idx = idx;
        rst       = r;
`ifdef AES_KS_ZEROIZE_EN
        zeroize   = z;
`endif
        acc = !r && !z && v && (!have_key || ec >= ea + 22);
        if (en && !r) begin
            ok = !acc && !z && have_key && (idx <= 4'd10) && (ec > ea) &&
                 (int'(idx) <= (ec - 1 - ea) / 2);
            e.ed   = ec;
            e.err  = !ok;
            e.data = ok ? (pin ? pin_val : exp_rk[idx]) : 128'h0;
            sb.push_back(e);
        end
        if (r || z) begin
            have_key = 0;
        end else if (acc) begin
            have_key = 1;
            ea = ec;
            expand(k);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(0, 128'h0, 0, 4'd0, 0, 0, 0, 128'h0);
    endtask

    task automatic rd(input logic [3:0] idx);
        tick(0, 128'h0, 1, idx, 0, 0, 0, 128'h0);
    endtask

    task automatic load(input logic [127:0] k);
        tick(1, k, 0, 4'd0, 0, 0, 0, 128'h0);
    endtask

    function automatic logic [127:0] rkey();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic bit rand_z();
`ifdef AES_KS_ZEROIZE_EN
        return ($urandom_range(0, 149) == 0);
`else
        return 1'b0;
`endif
    endfunction

    initial begin
        logic [127:0] k2;
        rst = 1'b1; key_valid = 1'b0; key_in = '0; rk_rd_en = 1'b0; rk_rd_idx = '0;
`ifdef AES_KS_ZEROIZE_EN
        zeroize = 1'b0;
`endif
        build_sbox();
        repeat (2) tick(0, 128'h0, 0, 4'd0, 1, 0, 0, 128'h0);
        idle(1);
        total++;
        if (rk_rd_err !== 1'b0 || rk_rd_data !== 128'h0) begin
            bad++;
            $display("FAIL reset_rd: got err=%b data=%h want err=0 data=0", rk_rd_err, rk_rd_data);
        end

        // Known-answer key, early reads, then pinned round keys.
        load(128'h000102030405060708090a0b0c0d0e0f);
        idle(1);
        rd(4'd3);
        for (int i = 0; i < 26; i++) rd(4'(i % 16));
        tick(0, 128'h0, 1, 4'd1,  0, 0, 1, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe);
        tick(0, 128'h0, 1, 4'd10, 0, 0, 1, 128'h13111d7fe3944a17f307a78b4d2b30c5);
        rd(4'd12);
        rd(4'd0);

        // key_valid held through expansion: second key only taken in DONE.
        load(rkey());
        k2 = rkey();
        for (int i = 0; i < 50; i++) tick(1, k2, 1, 4'($urandom_range(0, 15)), 0, 0, 0, 128'h0);
        for (int i = 0; i < 30; i++) rd(4'($urandom_range(0, 15)));

        // Reset mid-expansion.
        load(rkey());
        for (int i = 0; i < 10; i++) rd(4'($urandom_range(0, 15)));
        tick(0, 128'h0, 0, 4'd0, 1, 0, 0, 128'h0);
        rd(4'd0);
        rd(4'd12);

`ifdef AES_KS_ZEROIZE_EN
        // Wipe in DONE, then re-expand.
        load(rkey());
        idle(23);
        tick(0, 128'h0, 1, 4'd2, 0, 1, 0, 128'h0);
        for (int i = 0; i < 11; i++) rd(4'(i));
        load(rkey());
        for (int i = 0; i < 25; i++) rd(4'(i % 11));
`endif

        // Randomized traffic.
        for (int i = 0; i < 900; i++) begin
            tick($urandom_range(0, 9) == 0, rkey(), $urandom_range(0, 1) == 1,
                 4'($urandom_range(0, 15)), $urandom_range(0, 199) == 0, rand_z(), 0, 128'h0);
        end

        idle(4);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
